conv_scan_ctrl: RTL and testbench
=================================

# conv_scan_ctrl

Scan sequencer for one convolutional clause processing element. On `start` it walks a stride-1 P×P window (P = 3, 5 or 7) over an IMG_W×IMG_H booleanized image. It issues one pixel-column read per cycle and drives the PE's `pe_enable`/`conv_enable`. It tags each issued column with window coordinates for the position-match logic, and OR-reduces the PE's `clause_op` over all valid windows into a single clause result. It sits between the pixel buffer and the PE, under the clause-bank controller.

## Interface
- `IMG_W`, 28: image width in pixels (≥7).
- `IMG_H`, 28: image height in pixels (≥7).
- `CLAUSE_LAT`, 1: cycles from an issued column to its `clause_op` from the PE (1..4).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin scan; sampled only in IDLE.
- `patch_size`  in  3  P; latched on accepted `start`.
- `stall`  in  1  pixel buffer not ready; freezes issue.
- `clause_op`  in  1  PE clause output for the window issued CLAUSE_LAT cycles earlier.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  illegal `patch_size`; held until next accepted `start`.
- `conv_enable`  out  1  PE compare enable.
- `pe_enable`  out  1  PE shift/evaluate strobe.
- `col_x`  out  5  pixel column address being read.
- `row_y`  out  5  top row of the P-row column slice being read.
- `win_valid`  out  1  current issue completes a full window.
- `win_x`  out  5  window left column (`col_x`−P+1), 0 when `!win_valid`.
- `win_y`  out  5  window top row (= `row_y`).
- `clause_any`  out  1  OR of `clause_op` over all valid windows of the scan.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start`=1 with P∈{3,5,7}: latch P, clear `clause_any` and `err`, reset `col_x`=`row_y`=0, go to RUN.
  - Illegal P: set `err`, go straight to DONE; no pe_enable issued.
- **RUN**
  - `pe_enable` = !`stall`. On each issue, `col_x` increments.
  - At `col_x`=IMG_W−1: wrap to 0 and increment `row_y`.
  - `win_valid` = issue && `col_x` ≥ P−1. The first P−1 columns of every row are refill cycles with `win_valid`=0.
  - Last issue is at `col_x`=IMG_W−1, `row_y`=IMG_H−P; then go to DRAIN.
- **DRAIN**: hold CLAUSE_LAT cycles with `pe_enable`=0 so in-flight results are captured, then go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `conv_enable`=1 in RUN and DRAIN only.
- `busy`=1 in RUN, DRAIN and DONE.
- Result capture:
  - A CLAUSE_LAT-deep shift pipe carries `win_valid` and shifts every clock.
  - `clause_any` |= `clause_op` & pipe tail.
  - `clause_op` on non-valid slots (refill columns, stall bubbles) is ignored.
- Address arithmetic is unsigned 5-bit; compares use the latched P, never the live `patch_size` input.
- `start` while `busy` is ignored. `start` and `stall` in the same IDLE cycle: start is accepted, and the first RUN cycle honours `stall`.
- `rst` mid-scan: immediate return to IDLE. Pipe cleared, no `done` pulse.

## Timing
- Reset value of every output is 0.
- `start` accepted at edge k → first `pe_enable` in cycle k+1, unless `stall` is high then.
- No-stall RUN length = (IMG_H−P+1)·IMG_W cycles. Each stall cycle adds exactly one cycle.
- `done` arrives CLAUSE_LAT+1 cycles after the last issue cycle.
- `clause_any` is final and stable by the `done` cycle, and holds until the next accepted `start`.
- Illegal P: `err`=1 and `done`=1 in cycle k+1.

## Configuration
- `CONV_EARLY_EXIT_EN`
  - Defined: the first captured `clause_op`=1 during RUN ends issue immediately. The block goes to DRAIN (CLAUSE_LAT cycles), then DONE, and `clause_any`=1.
  - Undefined: the full scan always runs, and scan length is data-independent.

## Test plan
- 28×28 image, P=3, `clause_op` tied 0 → 728 `pe_enable` cycles, 2 refill columns per row (676 `win_valid`), `done` at cycle 728+CLAUSE_LAT+1 after start, `clause_any`=0.
- P=7, PE model asserts `clause_op` only for window (21,21) → `clause_any`=1. Without the macro, 616 issue cycles; with `CONV_EARLY_EXIT_EN`, issue stops right after the (27,21) column result is captured.
- P=5, random 30% `stall` → issue count still 672, `col_x`/`row_y` never skip or repeat, `done` delayed by exactly the number of stall cycles.
- `patch_size`=4 → `err`=1 and `done`=1 one cycle after start, no `pe_enable`. A following legal start clears `err`.
- `clause_op`=1 only on refill cycles (`col_x`<P−1) → `clause_any` stays 0.
- `rst` asserted mid-RUN → all outputs 0 asynchronously, no `done`. A new start runs a complete correct scan.

Source files
------------

// File: rtl/conv_scan_if.sv
// conv_scan_if: start/status, PE strobe and window-address bundle between the
// clause-bank controller / PE side (master) and conv_scan_ctrl (slave).
interface conv_scan_if;
  logic       start;
  logic [2:0] patch_size;
  logic       stall;
  logic       clause_op;
  logic       busy;
  logic       done;
  logic       err;
  logic       conv_enable;
  logic       pe_enable;
  logic [4:0] col_x;
  logic [4:0] row_y;
  logic       win_valid;
  logic [4:0] win_x;
  logic [4:0] win_y;
  logic       clause_any;

  modport master (
    output start, patch_size, stall, clause_op,
    input  busy, done, err, conv_enable, pe_enable, col_x, row_y,
           win_valid, win_x, win_y, clause_any
  );

  modport slave (
    input  start, patch_size, stall, clause_op,
    output busy, done, err, conv_enable, pe_enable, col_x, row_y,
           win_valid, win_x, win_y, clause_any
  );
endinterface

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: stride-1 PxP window scan sequencer for one convolutional clause PE.
// Optional CONV_EARLY_EXIT_EN: the first captured clause hit ends issue and drains.
module conv_scan_ctrl #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int CLAUSE_LAT = 1
) (
  input logic        clk,
  input logic        rst,
  conv_scan_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              p_q;
  logic [4:0]              col_q, row_q;
  logic [2:0]              dcnt;
  logic                    err_q, any_q;
  logic [CLAUSE_LAT-1:0]   vld_pipe;

  logic                    legal, accept, issue, last_issue, capture, drain_end;
  logic                    busy, done, conv_en, win_valid;
  logic [4:0]              p_m1, win_x;

  assign legal      = (bus.patch_size == 3'd3) || (bus.patch_size == 3'd5) ||
                      (bus.patch_size == 3'd7);
  assign accept     = (state == IDLE) && bus.start;
  assign p_m1       = {2'b00, p_q} - 5'd1;
  assign issue      = (state == RUN) && !bus.stall;
  assign last_issue = (col_q == 5'(IMG_W - 1)) && (row_q == 5'(IMG_H) - {2'b00, p_q});
  // pipe tail marks the clause_op slot that belongs to a real window
  assign capture    = bus.clause_op && vld_pipe[CLAUSE_LAT-1];
  assign drain_end  = (dcnt == 3'(CLAUSE_LAT - 1));

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = legal ? RUN : DONE;
`ifdef CONV_EARLY_EXIT_EN
      RUN:   if ((issue && last_issue) || capture) state_nxt = DRAIN;
`else
      RUN:   if (issue && last_issue) state_nxt = DRAIN;
`endif
      DRAIN: if (drain_end) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    conv_en   = 1'b0;
    win_valid = 1'b0;
    win_x     = 5'd0;
    case (state)
      RUN: begin
        busy      = 1'b1;
        conv_en   = 1'b1;
        win_valid = issue && (col_q >= p_m1);
        win_x     = win_valid ? (col_q - p_m1) : 5'd0;
      end
      DRAIN: begin
        busy    = 1'b1;
        conv_en = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // datapath: addresses, result pipe, sticky flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_q      <= 3'd0;
      col_q    <= 5'd0;
      row_q    <= 5'd0;
      dcnt     <= 3'd0;
      err_q    <= 1'b0;
      any_q    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= win_valid;
      for (int i = 1; i < CLAUSE_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      dcnt <= (state == DRAIN) ? dcnt + 3'd1 : 3'd0;
      if (accept) begin
        if (legal) p_q <= bus.patch_size;
        err_q <= !legal;
        any_q <= 1'b0;
        col_q <= 5'd0;
        row_q <= 5'd0;
      end else begin
        if (capture) any_q <= 1'b1;
        if (issue) begin
          if (last_issue) begin
            col_q <= 5'd0;
            row_q <= 5'd0;
          end else if (col_q == 5'(IMG_W - 1)) begin
            col_q <= 5'd0;
            row_q <= row_q + 5'd1;
          end else begin
            col_q <= col_q + 5'd1;
          end
        end
      end
    end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.err         = err_q;
  assign bus.conv_enable = conv_en;
  assign bus.pe_enable   = issue;
  assign bus.col_x       = col_q;
  assign bus.row_y       = row_q;
  assign bus.win_valid   = win_valid;
  assign bus.win_x       = win_x;
  assign bus.win_y       = row_q;
  assign bus.clause_any  = any_q;
endmodule

// File: tb/tb_conv_scan_ctrl.sv
// tb_conv_scan_ctrl: directed scans with hand-computed totals; a monitor checks
// each scan against a scoreboard entry when done is presented.
module tb_conv_scan_ctrl;
  localparam int LAT = 2;
  localparam int W   = 28;
  localparam int H   = 28;

  typedef struct {
    int p;
    int iss;
    int win;
    bit any;
    bit err;
  } scan_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   mode = 0;
  scan_t sb[$];

  conv_scan_if bus();

  conv_scan_ctrl #(.IMG_W(W), .IMG_H(H), .CLAUSE_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [26:0] outs;
  assign outs = {bus.busy, bus.done, bus.err, bus.conv_enable, bus.pe_enable,
                 bus.col_x, bus.row_y, bus.win_valid, bus.win_x, bus.win_y,
                 bus.clause_any};

  // PE model: clause_op answers for the issue made LAT cycles earlier
  logic d_wv [LAT];
  int   d_wx [LAT];
  int   d_wy [LAT];
  logic pe_op;

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        d_wv[i] <= 1'b0; d_wx[i] <= 0; d_wy[i] <= 0;
      end
    end else begin
      d_wv[0] <= bus.win_valid;
      d_wx[0] <= int'(bus.win_x);
      d_wy[0] <= int'(bus.win_y);
      for (int i = 1; i < LAT; i++) begin
        d_wv[i] <= d_wv[i-1]; d_wx[i] <= d_wx[i-1]; d_wy[i] <= d_wy[i-1];
      end
    end

  always_comb begin
    pe_op = 1'b0;
    case (mode)
      1: pe_op = d_wv[LAT-1] && (d_wx[LAT-1] == 21) && (d_wy[LAT-1] == 21);
      2: pe_op = !d_wv[LAT-1];
      default: pe_op = 1'b0;
    endcase
  end
  assign bus.clause_op = pe_op;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  initial begin
    bit    trk = 0;
    int    cyc = 0, iss = 0, wins = 0, stl = 0, bad = 0, ecol = 0, erow = 0;
    scan_t cur;
    cur = '{p:0, iss:0, win:0, any:0, err:0};
    forever begin
      @(negedge clk);
      if (rst) begin
        if (trk && sb.size() > 0) void'(sb.pop_front());
        trk = 0;
        continue;
      end
      if (trk) begin
        cyc++;
        if (bus.stall && iss < cur.iss) stl++;
        if (bus.pe_enable) begin
          if (int'(bus.col_x) != ecol || int'(bus.row_y) != erow) bad++;
          if (bus.win_valid != (int'(bus.col_x) >= cur.p - 1)) bad++;
          if (bus.win_valid && (int'(bus.win_x) != int'(bus.col_x) - cur.p + 1 ||
                                bus.win_y != bus.row_y)) bad++;
          iss++;
          if (ecol == W - 1) begin ecol = 0; erow++; end
          else ecol++;
        end else if (bus.win_valid) bad++;
        if (!bus.win_valid && bus.win_x != 5'd0) bad++;
        if (bus.win_valid) wins++;
        if (bus.done) begin
          chk("err", bus.err, cur.err);
          chk("clause_any", bus.clause_any, cur.any);
          chk("issues", iss, cur.iss);
          chk("windows", wins, cur.win);
          chk("latency", cyc, cur.err ? 1 : cur.iss + stl + LAT + 1);
          chk("coord_bad", bad, 0);
          chk("done_busy", bus.busy, 1);
          chk("done_conv_en", bus.conv_enable, 0);
          void'(sb.pop_front());
          trk = 0;
          done_cnt++;
        end
      end else if (bus.done) begin
        chk("stray_done", bus.done, 0);
      end
      if (!trk && bus.start && !bus.busy && sb.size() > 0) begin
        cur = sb[0];
        trk = 1; cyc = 0; iss = 0; wins = 0; stl = 0; bad = 0; ecol = 0; erow = 0;
      end
    end
  end

  task automatic pulse_rst();
    @(posedge clk); #3 rst = 1'b1;
    #1 chk("rst_outs", int'(outs), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_scan(input int p, input int m, input int pct, input bit st0,
                          input int e_iss, input int e_win, input bit e_any,
                          input bit e_err);
    int n0;
    bit ok;
    n0 = done_cnt;
    ok = 0;
    sb.push_back('{p:p, iss:e_iss, win:e_win, any:e_any, err:e_err});
    @(posedge clk); #1;
    mode = m;
    bus.patch_size = 3'(p);
    bus.start = 1'b1;
    bus.stall = st0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt != n0) begin ok = 1; break; end
      bus.stall = (pct > 0) && ($urandom_range(99) < pct);
      @(posedge clk); #1;
    end
    bus.stall = 1'b0;
    if (!ok) begin
      chk("scan_timeout", 0, 1);
      pulse_rst();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.patch_size = 3'd0;
    bus.stall = 1'b0;
    #1 chk("reset_outs", int'(outs), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) chk("post_reset_outs", int'(outs), 0);

    run_scan(3, 0, 0, 0, 728, 676, 0, 0);
    run_scan(7, 1, 0, 0, 616, 484, 1, 0);
    run_scan(5, 0, 30, 1, 672, 576, 0, 0);
    run_scan(4, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 chk("err_held", bus.err, 1);
    chk("idle_busy", bus.busy, 0);
    run_scan(3, 2, 20, 0, 728, 676, 0, 0);
    chk("err_cleared", bus.err, 0);

    // abort mid-RUN, then a complete scan must still be correct
    sb.push_back('{p:5, iss:672, win:576, any:1, err:0});
    @(posedge clk); #1;
    mode = 1; bus.patch_size = 3'd5; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (100) @(posedge clk);
    pulse_rst();
    @(negedge clk) chk("after_abort_idle", int'(outs), 0);

    run_scan(7, 1, 0, 0, 616, 484, 1, 0);
`ifdef CONV_EARLY_EXIT_EN
    run_scan(5, 1, 0, 0, 616, 528, 1, 0);
`else
    run_scan(5, 1, 0, 0, 672, 576, 1, 0);
`endif
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
